// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART TX arbitration slice.
package uart_pkg;

  localparam int unsigned DBIT_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin winner selection: first valid requester above last_grant, wrapping.
module rr_pick
  import uart_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned GW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [GW-1:0]   last_grant,
  output logic [GW-1:0]   winner,
  output logic            any_valid
);

  int unsigned   idx;
  logic [GW-1:0] sel;

  // Walk the requesters starting one above the last grant and keep the first hit.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    sel       = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(last_grant) + i) % NREQ;
      sel = GW'(idx);
      if (!any_valid && req_valid[sel]) begin
        winner    = sel;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte producers,
// with optional inter-frame gap and completion timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DBIT        = DBIT_DEF,
  parameter int unsigned GAP_CYC     = 0,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DBIT-1:0]     req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [DBIT-1:0]          tx_din,
  input  logic                     tx_done_tick,
  output logic [clog2(NREQ)-1:0]   grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned GW       = clog2(NREQ);
  localparam int unsigned TW       = clog2(TIMEOUT_CYC);
  localparam int unsigned GCW      = (clog2(GAP_CYC + 1) > 0) ? clog2(GAP_CYC + 1) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

  arb_state_t     state;
  logic [GW-1:0]  last_grant;
  logic [TW-1:0]  tmo_cnt;
  logic [GCW-1:0] gap_cnt;
  logic [GW-1:0]  winner;
  logic           any_valid;

  rr_pick #(
    .NREQ (NREQ),
    .GW   (GW)
  ) u_pick (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // Frame sequencing FSM with registered handshake, transmitter and status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      req_ready   <= '0;
      tx_start    <= 1'b0;
      tx_din      <= '0;
      grant_id    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      last_grant  <= GW'(NREQ - 1);
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            state      <= ST_START;
            tx_start   <= 1'b1;
            tx_din     <= req_data[winner*DBIT +: DBIT];
            req_ready  <= NREQ'(1) << winner;
            grant_id   <= winner;
            last_grant <= winner;
            busy       <= 1'b1;
          end
        end
        ST_START: begin
          state     <= ST_WAIT;
          tx_start  <= 1'b0;
          req_ready <= '0;
          tmo_cnt   <= '0;
        end
        ST_WAIT: begin
          // A tick coinciding with expiry is a normal completion.
          if (tx_done_tick || (tmo_cnt == TW'(TIMEOUT_CYC - 1))) begin
            timeout_err <= !tx_done_tick;
            if (GAP_CYC > 0) begin
              state   <= ST_GAP;
              gap_cnt <= '0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt == GCW'(GAP_LAST)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GCW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter: two instances (no gap / 5-cycle gap),
// both with a 32-cycle timeout, checked every cycle against a frame-level model.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int TMO  = 32;
  localparam int NCYC = 6000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n [2];
  logic [NR-1:0] rv    [2];
  logic [NR*DW-1:0] rd [2];
  logic          tick  [2];
  logic [NR-1:0] rdy   [2];
  logic          st    [2];
  logic [DW-1:0] din   [2];
  logic [1:0]    gid   [2];
  logic          bsy   [2];
  logic          terr  [2];

  uart_tx_arbiter #(.NREQ(NR), .DBIT(DW), .GAP_CYC(0), .TIMEOUT_CYC(TMO)) dut_nogap (
    .clk(clk), .reset_n(rst_n[0]), .req_valid(rv[0]), .req_data(rd[0]),
    .req_ready(rdy[0]), .tx_start(st[0]), .tx_din(din[0]), .tx_done_tick(tick[0]),
    .grant_id(gid[0]), .busy(bsy[0]), .timeout_err(terr[0])
  );

  uart_tx_arbiter #(.NREQ(NR), .DBIT(DW), .GAP_CYC(5), .TIMEOUT_CYC(TMO)) dut_gap (
    .clk(clk), .reset_n(rst_n[1]), .req_valid(rv[1]), .req_data(rd[1]),
    .req_ready(rdy[1]), .tx_start(st[1]), .tx_din(din[1]), .tx_done_tick(tick[1]),
    .grant_id(gid[1]), .busy(bsy[1]), .timeout_err(terr[1])
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a frame is "in flight" for some age since its grant; it ends
  // on a tick at age >= 1 or is aborted at age TMO; then gap_left idle-busy cycles.
  int            gap_cfg [2] = '{0, 5};
  int            m_last  [2];
  int            m_age   [2];
  int            m_gapl  [2];
  bit            m_inf   [2];
  logic [NR-1:0] m_rdy   [2];
  bit            m_st    [2];
  logic [DW-1:0] m_din   [2];
  int            m_gid   [2];
  bit            m_busy  [2];
  bit            m_terr  [2];
  int            cd      [2];

  task automatic model_step(input int k);
    int w;
    int c;
    if (!rst_n[k]) begin
      m_last[k] = NR - 1; m_inf[k] = 0; m_age[k] = 0; m_gapl[k] = 0;
      m_rdy[k] = '0; m_st[k] = 0; m_din[k] = '0; m_gid[k] = 0;
      m_busy[k] = 0; m_terr[k] = 0;
      return;
    end
    m_terr[k] = 0;
    m_st[k]   = 0;
    m_rdy[k]  = '0;
    if (m_inf[k]) begin
      if (m_age[k] >= 1 && tick[k]) begin
        m_inf[k]  = 0;
        m_gapl[k] = gap_cfg[k];
      end else if (m_age[k] == TMO) begin
        m_inf[k]  = 0;
        m_gapl[k] = gap_cfg[k];
        m_terr[k] = 1;
      end else begin
        m_age[k]++;
      end
    end else if (m_gapl[k] > 0) begin
      m_gapl[k]--;
    end else if (rv[k] != '0) begin
      w = -1;
      for (int j = 1; j <= NR; j++) begin
        c = (m_last[k] + j) % NR;
        if (w < 0 && rv[k][c]) w = c;
      end
      m_last[k] = w;
      m_gid[k]  = w;
      m_din[k]  = rd[k][w*DW +: DW];
      m_rdy[k]  = NR'(1) << w;
      m_st[k]   = 1;
      m_inf[k]  = 1;
      m_age[k]  = 0;
    end
    m_busy[k] = m_inf[k] || (m_gapl[k] > 0);
  endtask

  // Requesters follow the hold-until-ready protocol (with occasional withdrawal);
  // the transmitter answers each tx_start after a random latency, sometimes never,
  // sometimes exactly at timeout expiry; stray ticks and resets are sprinkled in.
  task automatic drive(input int k, input int cyc);
    int  r;
    bit  full;
    full     = (cyc >= 1000 && cyc < 2000);
    rst_n[k] = (cyc < 2) ? 1'b0 : (full || $urandom_range(0, 399) != 0);
    tick[k]  = 1'b0;
    if (st[k]) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       cd[k] = -1;
        1:       cd[k] = TMO + 1;
        2:       cd[k] = TMO;
        3:       cd[k] = 1;
        default: cd[k] = $urandom_range(2, 25);
      endcase
    end
    if (cd[k] > 0) cd[k]--;
    if (cd[k] == 0) begin
      tick[k] = 1'b1;
      cd[k]   = -1;
    end else if (cd[k] < 0 && $urandom_range(0, 59) == 0) begin
      tick[k] = 1'b1;
    end
    for (int i = 0; i < NR; i++) begin
      if (rv[k][i] && rdy[k][i]) begin
        rv[k][i] = 1'b0;
      end else if (rv[k][i] && !full && $urandom_range(0, 59) == 0) begin
        rv[k][i] = 1'b0;
      end else if (!rv[k][i] && (full || $urandom_range(0, 2) == 0)) begin
        rv[k][i] = 1'b1;
        rd[k][i*DW +: DW] = 8'($urandom);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0;
      rv[k]    = '0;
      rd[k]    = '0;
      tick[k]  = 1'b0;
      cd[k]    = -1;
      model_step(k);
    end
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("d%0d.req_ready@%0d", k, cyc), 32'(rdy[k]), 32'(m_rdy[k]));
        chk($sformatf("d%0d.tx_start@%0d", k, cyc), 32'(st[k]), 32'(m_st[k]));
        chk($sformatf("d%0d.tx_din@%0d", k, cyc), 32'(din[k]), 32'(m_din[k]));
        chk($sformatf("d%0d.grant_id@%0d", k, cyc), 32'(gid[k]), 32'(m_gid[k]));
        chk($sformatf("d%0d.busy@%0d", k, cyc), 32'(bsy[k]), 32'(m_busy[k]));
        chk($sformatf("d%0d.timeout_err@%0d", k, cyc), 32'(terr[k]), 32'(m_terr[k]));
      end
      for (int k = 0; k < 2; k++) begin
        drive(k, cyc);
        model_step(k);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
